// File: rtl/alu_entry_pkg.sv
// Shared types for the ALU operand-entry sequencer.
//   state_e      : entry FSM states (2-bit)
//   opcode_e     : ALU opcode encoding (carried through, not interpreted here)
//   state_onehot : maps a state to the one-hot LED pattern
package alu_entry_pkg;

  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    SHOW    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_OR  = 2'b10,
    OP_AND = 2'b11
  } opcode_e;

  // Encoding value doubles as LED bit index: WAIT_A->bit0 ... SHOW->bit3.
  function automatic logic [3:0] state_onehot(state_e s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/rising_edge_detector.sv
// Rising-edge pulse generator for a debounced button level.
//   clk   : system clock
//   reset : synchronous active-high reset
//   level : debounced button level
//   pulse : level & ~prev, high for one cycle per press
// prev resets to 1 so a button held through reset never fires.
module rising_edge_detector (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b1;
    else       prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/alu_entry_sequencer.sv
// Operand-entry controller for the board ALU calculator.
//   clk, reset : clock, synchronous active-high reset
//   sw         : switch value
//   enter/back : confirm / undo button levels
//   result     : ALU result (combinational from A/B/OpCode)
//   A, B       : registered zero-extended operands
//   OpCode     : registered opcode (sw[1:0])
//   disp_value : live switches during entry, result in SHOW
//   state_leds : one-hot state indicator
//   done       : one-cycle pulse after entering SHOW
module alu_entry_sequencer
  import alu_entry_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SW_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] sw,
  input  logic                enter,
  input  logic                back,
  input  logic [WIDTH-1:0]    result,
  output logic [WIDTH-1:0]    A,
  output logic [WIDTH-1:0]    B,
  output logic [1:0]          OpCode,
  output logic [WIDTH-1:0]    disp_value,
  output logic [3:0]          state_leds,
  output logic                done
);

  localparam int NUM_BTN = 2;

  // bit0 = enter, bit1 = back
  logic [NUM_BTN-1:0] btn_level, btn_pulse;
  logic               enter_p, back_p, accept;
  logic [WIDTH-1:0]   sw_zext;
  state_e             state, state_n;

  assign btn_level = {back, enter};

  rising_edge_detector u_btn [NUM_BTN-1:0] (
    .clk   (clk),
    .reset (reset),
    .level (btn_level),
    .pulse (btn_pulse)
  );

  assign enter_p = btn_pulse[0];
  assign back_p  = btn_pulse[1];
  // back wins a same-cycle collision; the enter press is dropped.
  assign accept  = enter_p & ~back_p;
  assign sw_zext = WIDTH'(sw);

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_A;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (back_p) begin
      case (state)
        WAIT_A:  state_n = WAIT_A;
        WAIT_B:  state_n = WAIT_A;
        WAIT_OP: state_n = WAIT_B;
        SHOW:    state_n = WAIT_OP;
        default: state_n = WAIT_A;
      endcase
    end else if (enter_p) begin
      case (state)
        WAIT_A:  state_n = WAIT_B;
        WAIT_B:  state_n = WAIT_OP;
        WAIT_OP: state_n = SHOW;
        SHOW:    state_n = WAIT_A;
        default: state_n = WAIT_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      A      <= '0;
      B      <= '0;
      OpCode <= '0;
      done   <= 1'b0;
    end else begin
      done <= accept && (state == WAIT_OP);
      if (accept) begin
        case (state)
          WAIT_A:  A      <= sw_zext;
          WAIT_B:  B      <= sw_zext;
          WAIT_OP: OpCode <= sw[1:0];
          default: ;
        endcase
      end
    end
  end

  assign disp_value = (state == SHOW) ? result : sw_zext;
  assign state_leds = state_onehot(state);

endmodule

// File: tb/tb_alu_entry_sequencer.sv
module tb_alu_entry_sequencer;

  logic        clk, reset, enter, back;
  logic [15:0] sw;
  logic [31:0] result, A, B, disp_value;
  logic [1:0]  OpCode;
  logic [3:0]  state_leds;
  logic        done;

  alu_entry_sequencer #(.WIDTH(32), .SW_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .sw(sw), .enter(enter), .back(back),
    .result(result), .A(A), .B(B), .OpCode(OpCode),
    .disp_value(disp_value), .state_leds(state_leds), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a | b;
      default: return a & b;
    endcase
  endfunction

  // ALU stand-in driving the result input
  always_comb result = alu(A, B, OpCode);

  typedef struct {
    logic [31:0] a, b, disp;
    logic [1:0]  op;
    logic [3:0]  leds;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0, nfail = 0;

  // reference model
  int          m_st = 0;
  logic [31:0] m_a = 0, m_b = 0;
  logic [1:0]  m_op = 0;
  logic        m_done = 0, m_pe = 1, m_pb = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic [15:0] s, input logic e, input logic b, input logic r);
    exp_t x;
    logic ep, bp;
    sw = s; enter = e; back = b; reset = r;
    ep = e & ~m_pe;
    bp = b & ~m_pb;
    if (r) begin
      m_st = 0; m_a = 0; m_b = 0; m_op = 0; m_done = 0; m_pe = 1; m_pb = 1;
    end else begin
      m_done = 0;
      if (bp) begin
        if (m_st != 0) m_st = m_st - 1;
      end else if (ep) begin
        case (m_st)
          0: begin m_a = {16'h0, s}; m_st = 1; end
          1: begin m_b = {16'h0, s}; m_st = 2; end
          2: begin m_op = s[1:0]; m_st = 3; m_done = 1; end
          default: m_st = 0;
        endcase
      end
      m_pe = e; m_pb = b;
    end
    x.a = m_a; x.b = m_b; x.op = m_op; x.done = m_done;
    x.leds = 4'b0001 << m_st;
    x.disp = (m_st == 3) ? alu(m_a, m_b, m_op) : {16'h0, s};
    sb.push_back(x);
    @(posedge clk); #1;
    x = sb.pop_front();
    chk("A", A, x.a);
    chk("B", B, x.b);
    chk("op", {30'h0, OpCode}, {30'h0, x.op});
    chk("leds", {28'h0, state_leds}, {28'h0, x.leds});
    chk("done", {31'h0, done}, {31'h0, x.done});
    chk("disp", disp_value, x.disp);
  endtask

  task automatic press(input logic [15:0] s);
    step(s, 1'b1, 1'b0, 1'b0);
    step(s, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_back(input logic [15:0] s);
    step(s, 1'b0, 1'b1, 1'b0);
    step(s, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    sw = 0; enter = 0; back = 0; reset = 1;
    step(16'h0, 0, 0, 1);
    step(16'h0, 0, 0, 1);
    chk("rst_leds", {28'h0, state_leds}, 32'h1);
    chk("rst_A", A, 32'h0);
    step(16'h0, 0, 0, 0);

    // basic entry: A=0x11, B=0x11, ADD
    step(16'h0011, 1, 0, 0);
    step(16'h0011, 0, 0, 0);
    press(16'h0011);
    step(16'h0000, 1, 0, 0);
    chk("t1_done", {31'h0, done}, 32'h1);
    step(16'h0000, 0, 0, 0);
    chk("t1_A", A, 32'h11);
    chk("t1_B", B, 32'h11);
    chk("t1_leds", {28'h0, state_leds}, 32'h8);
    chk("t1_disp", disp_value, 32'h22);
    chk("t1_done_once", {31'h0, done}, 32'h0);
    press(16'h0000);                       // SHOW -> WAIT_A

    // held enter produces a single advance
    repeat (5) step(16'h0022, 1, 0, 0);
    step(16'h0022, 0, 0, 0);
    chk("t2_A", A, 32'h22);
    chk("t2_leds", {28'h0, state_leds}, 32'h2);

    // back from WAIT_B, then back in WAIT_A
    press_back(16'h0055);
    chk("t3_leds", {28'h0, state_leds}, 32'h1);
    chk("t3_A", A, 32'h22);
    press_back(16'h0055);
    chk("t3_leds2", {28'h0, state_leds}, 32'h1);

    // enter+back collision in WAIT_OP
    press(16'h0033);
    press(16'h0044);
    step(16'h0003, 1, 1, 0);
    chk("t4_done", {31'h0, done}, 32'h0);
    step(16'h0003, 0, 0, 0);
    chk("t4_leds", {28'h0, state_leds}, 32'h2);
    chk("t4_op", {30'h0, OpCode}, 32'h0);

    // zero extension
    press_back(16'h0000);
    press(16'hFFFF);
    chk("t5_A", A, 32'h0000FFFF);

    // reset mid-press in WAIT_OP with enter held
    press(16'h0001);
    step(16'h0002, 1, 0, 1);
    chk("t6_A", A, 32'h0);
    chk("t6_leds", {28'h0, state_leds}, 32'h1);
    repeat (3) step(16'h0002, 1, 0, 0);
    chk("t6_hold", {28'h0, state_leds}, 32'h1);
    step(16'h0002, 0, 0, 0);
    press(16'h0007);
    chk("t6_A2", A, 32'h7);
    chk("t6_leds2", {28'h0, state_leds}, 32'h2);

    // random traffic against the model
    for (int i = 0; i < 300; i++)
      step(16'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 60) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
